// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio output path.
// Frame word layout, power-down codes and transmitter FSM states.
package audio_pkg;

   localparam int DAC_WORD_W = 16;
   localparam int DAC_DATA_W = 12;

   localparam logic [1:0] PD_NORMAL = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } dac_state_t;

   // Word as seen by the DAC: two don't-care zeros, PD bits, code.
   function automatic logic [DAC_WORD_W-1:0] dac_word(
      input logic [1:0]            pd,
      input logic [DAC_DATA_W-1:0] code
   );
      return {2'b00, pd, code};
   endfunction

endpackage

// File: rtl/audio_dac_transmitter_sclk_divider.sv
// sclk_divider: SCLK phase generator for the DAC transmitter.
// Ports: clk, reset (async low), clr (restart at high phase), en,
//   sclk_high (current phase), rise/fall (last cycle before edge).
module sclk_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic sclk_high,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          high;
   logic          at_last;

   assign at_last   = (cnt == LAST);
   assign sclk_high = high;
   assign rise      = en & ~high & at_last;
   assign fall      = en & high & at_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         high <= 1'b1;
      end else if (clr) begin
         cnt  <= '0;
         high <= 1'b1;
      end else if (en) begin
         if (at_last) begin
            cnt  <= '0;
            high <= ~high;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/audio_dac_transmitter.sv
// audio_dac_transmitter: dual-channel 12-bit serial DAC writer.
// Ports: clk, reset (async low); in_valid/in_ready handshake with
//   sample_a, sample_b, pd_mode; dac_sync, dac_sclk, dac_d0, dac_d1
//   to the DACs; busy, frame_done pulse and frame_count status.
module audio_dac_transmitter
   import audio_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DAC_DATA_W-1:0] sample_a,
   input  logic [DAC_DATA_W-1:0] sample_b,
   input  logic [1:0]            pd_mode,
   output logic                  dac_sync,
   output logic                  dac_sclk,
   output logic                  dac_d0,
   output logic                  dac_d1,
   output logic                  busy,
   output logic                  frame_done,
   output logic [15:0]           frame_count
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   dac_state_t state;

   logic                  buf_full;
   logic [DAC_DATA_W-1:0] buf_a;
   logic [DAC_DATA_W-1:0] buf_b;
   logic [1:0]            buf_pd;

   logic [DAC_WORD_W-1:0] sr_a;
   logic [DAC_WORD_W-1:0] sr_b;
   logic [3:0]            bit_cnt;
   logic [GW-1:0]         gap_cnt;

   logic shifting;
   logic gap_first;
   logic gap_end;
   logic load;
   logic accept;
   logic sclk_high;
   logic rise;
   logic fall;

   assign in_ready  = ~buf_full;
   assign accept    = in_valid & ~buf_full;
   assign shifting  = (state == SHIFT);
   assign gap_first = (state == GAP) && (gap_cnt == '0);
   assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
   assign load      = buf_full && ((state == IDLE) || gap_end);

   // One-entry holding buffer: write when empty, read when full.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_full <= 1'b0;
         buf_a    <= '0;
         buf_b    <= '0;
         buf_pd   <= PD_NORMAL;
      end else if (accept) begin
         buf_full <= 1'b1;
         buf_a    <= sample_a;
         buf_b    <= sample_b;
         buf_pd   <= pd_mode;
      end else if (load) begin
         buf_full <= 1'b0;
      end
   end

   sclk_divider #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_divider (
      .clk       (clk),
      .reset     (reset),
      .clr       (load),
      .en        (shifting),
      .sclk_high (sclk_high),
      .rise      (rise),
      .fall      (fall)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         sr_a        <= '0;
         sr_b        <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         dac_sync    <= 1'b1;
         dac_sclk    <= 1'b1;
         dac_d0      <= 1'b0;
         dac_d1      <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         // Line outputs are registered images of the previous
         // cycle's state, so they trail the FSM by one clock.
         dac_sync   <= ~shifting;
         dac_sclk   <= ~shifting | sclk_high;
         dac_d0     <= shifting & sr_a[DAC_WORD_W-1];
         dac_d1     <= shifting & sr_b[DAC_WORD_W-1];
         busy       <= (state != IDLE);
         frame_done <= gap_first;
         if (gap_first) begin
            frame_count <= frame_count + 16'd1;
         end

         unique case (state)
            IDLE: begin
            end
            SHIFT: begin
               if (fall) begin
                  bit_cnt <= bit_cnt + 4'd1;
               end
               if (rise) begin
                  sr_a <= sr_a << 1;
                  sr_b <= sr_b << 1;
                  // 4-bit count wraps to zero after the 16th fall.
                  if (bit_cnt == '0) begin
                     state   <= GAP;
                     gap_cnt <= '0;
                  end
               end
            end
            GAP: begin
               gap_cnt <= gap_cnt + GW'(1);
               if (gap_end) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (load) begin
            sr_a    <= dac_word(buf_pd, buf_a);
            sr_b    <= dac_word(buf_pd, buf_b);
            bit_cnt <= '0;
            state   <= SHIFT;
         end
      end
   end

endmodule

// File: tb/tb_audio_dac_transmitter.sv
// tb_audio_dac_transmitter: bench for audio_dac_transmitter.
// Frame-level model decodes the serial lines and checks them.
module tb_audio_dac_transmitter;

   localparam int D = 2;
   localparam int G = 2;
   localparam logic [22:0] IDLE_VEC =
      {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] sample_a = '0;
   logic [11:0] sample_b = '0;
   logic [1:0]  pd_mode = '0;
   logic        dac_sync;
   logic        dac_sclk;
   logic        dac_d0;
   logic        dac_d1;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_count;

   audio_dac_transmitter #(
      .CLK_DIV    (D),
      .GAP_CYCLES (G)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sample_a    (sample_a),
      .sample_b    (sample_b),
      .pd_mode     (pd_mode),
      .dac_sync    (dac_sync),
      .dac_sclk    (dac_sclk),
      .dac_d0      (dac_d0),
      .dac_d1      (dac_d1),
      .busy        (busy),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected words, appended on every accepted handshake.
   logic [15:0] qa[$];
   logic [15:0] qb[$];

   always @(posedge clk) begin
      if (!reset) begin
         qa.delete();
         qb.delete();
      end else if (in_valid && in_ready) begin
         qa.push_back(16'(int'(pd_mode) * 4096 + int'(sample_a)));
         qb.push_back(16'(int'(pd_mode) * 4096 + int'(sample_b)));
      end
   end

   // Line decoder and frame checker.
   logic        prev_sync = 1'b1;
   logic        prev_sclk = 1'b1;
   logic [15:0] wa, wb, last_wa, last_wb, ea, eb;
   int          low_len = 0;
   int          falls = 0;
   int          hi_len = 0;
   int          fall_cyc = 0;
   int          last_gap = 0;
   int          last_spacing = 0;
   int          frames_seen = 0;
   int          mdl_frames = 0;
   int          count_base = 0;
   bit          seen = 1'b0;
   bit          have_fall = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         prev_sync  = 1'b1;
         prev_sclk  = 1'b1;
         low_len    = 0;
         falls      = 0;
         hi_len     = 0;
         mdl_frames = 0;
         seen       = 1'b0;
         have_fall  = 1'b0;
      end else begin
         if (!dac_sync) begin
            if (prev_sync) begin
               low_len = 0;
               falls   = 0;
               wa      = '0;
               wb      = '0;
               if (have_fall) last_spacing = cyc - fall_cyc;
               if (seen) last_gap = hi_len;
               fall_cyc  = cyc;
               have_fall = 1'b1;
            end
            low_len++;
            if (prev_sclk && !dac_sclk) begin
               falls++;
               wa = {wa[14:0], dac_d0};
               wb = {wb[14:0], dac_d1};
            end
            chk("busy_in_frame", busy, 1);
            chk("no_done_in_frame", frame_done, 0);
         end else begin
            chk("idle_lines", {dac_sclk, dac_d0, dac_d1}, 3'b100);
            if (!prev_sync) begin
               chk("frame_len", low_len, 32 * D);
               chk("sclk_falls", falls, 16);
               chk("frame_done", frame_done, 1);
               chk("frame_expected", qa.size() > 0, 1);
               if (qa.size() > 0) begin
                  ea = qa.pop_front();
                  eb = qb.pop_front();
                  chk("word_d0", wa, ea);
                  chk("word_d1", wb, eb);
               end
               mdl_frames++;
               chk("frame_count", frame_count,
                   32'(16'(count_base + mdl_frames)));
               last_wa = wa;
               last_wb = wb;
               frames_seen++;
               seen   = 1'b1;
               hi_len = 0;
            end else begin
               chk("no_stray_done", frame_done, 0);
            end
            hi_len++;
         end
         prev_sync = dac_sync;
         prev_sclk = dac_sclk;
      end
   end

   task automatic do_reset();
      in_valid = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1 chk("reset_outputs",
             {dac_sync, dac_sclk, dac_d0, dac_d1, in_ready,
              busy, frame_done, frame_count}, IDLE_VEC);
      count_base = 0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic send(input logic [11:0] a,
                       input logic [11:0] b,
                       input logic [1:0]  pd,
                       input bit          hold,
                       output int         acc);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("ready_timeout", n < 2000, 1);
      sample_a = a;
      sample_b = b;
      pd_mode  = pd;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      if (!hold) in_valid = 1'b0;
      chk("ready_low_after_accept", in_ready, 0);
   endtask

   task automatic wait_frames(input int target);
      int n;
      n = 0;
      while (frames_seen < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("frame_timeout", frames_seen >= target, 1);
   endtask

   int acc0, acc1, acc2, fs_before;

   initial begin
      do_reset();

      repeat (100) begin
         @(negedge clk);
         chk("idle_outputs",
             {dac_sync, dac_sclk, dac_d0, dac_d1, in_ready,
              busy, frame_done, frame_count}, IDLE_VEC);
      end

      send(12'hA5C, 12'h3F1, 2'b00, 1'b0, acc0);
      @(negedge clk);
      chk("ready_after_load", in_ready, 1);
      wait_frames(frames_seen + 1);
      chk("sync_latency", fall_cyc - acc0, 2);
      chk("single_d0", last_wa, 16'h0A5C);
      chk("single_d1", last_wb, 16'h03F1);
      chk("single_count", frame_count, 1);
      repeat (5) @(negedge clk);
      chk("busy_cleared", busy, 0);

      do_reset();
      fs_before = frames_seen;
      send(12'h123, 12'hABC, 2'b00, 1'b1, acc0);
      send(12'hFFF, 12'h000, 2'b01, 1'b1, acc1);
      send(12'h800, 12'h7FF, 2'b10, 1'b1, acc2);
      chk("accept_spacing", acc2 - acc1, 66);
      in_valid = 1'b0;
      wait_frames(fs_before + 2);
      chk("gap_2", last_gap, G);
      chk("spacing_2", last_spacing, 66);
      chk("b2b_d0_2", last_wa, 16'h1FFF);
      wait_frames(fs_before + 3);
      chk("gap_3", last_gap, G);
      chk("spacing_3", last_spacing, 66);
      chk("b2b_d0_3", last_wa, 16'h2800);
      chk("b2b_d1_3", last_wb, 16'h27FF);
      chk("b2b_count", frame_count, 3);

      send(12'hFFF, 12'h001, 2'b11, 1'b0, acc0);
      wait_frames(frames_seen + 1);
      chk("pd_d0", last_wa, 16'h3FFF);
      chk("pd_d1", last_wb, 16'h3001);

      fs_before = frames_seen;
      send(12'h0F0, 12'h00F, 2'b00, 1'b0, acc0);
      begin
         int n;
         n = 0;
         while ((dac_sync || falls < 9) && n < 2000) begin
            @(negedge clk);
            n++;
         end
         chk("bit7_timeout", n < 2000, 1);
      end
      do_reset();
      repeat (20) @(negedge clk);
      chk("no_frame_on_reset", frames_seen, fs_before);
      chk("count_after_reset", frame_count, 0);
      send(12'h555, 12'hAAA, 2'b00, 1'b0, acc0);
      wait_frames(fs_before + 1);
      chk("recover_d0", last_wa, 16'h0555);
      chk("recover_d1", last_wb, 16'h0AAA);
      chk("recover_count", frame_count, 1);

      do_reset();
      @(negedge clk);
      force dut.frame_count = 16'hFFFF;
      @(negedge clk);
      release dut.frame_count;
      count_base = 16'hFFFF;
      @(negedge clk);
      chk("preset_count", frame_count, 16'hFFFF);
      send(12'h001, 12'h800, 2'b01, 1'b0, acc0);
      wait_frames(frames_seen + 1);
      chk("wrap_count", frame_count, 16'h0000);
      chk("wrap_d1", last_wb, 16'h1800);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/audio_dac_transmitter.md
Name: audio_dac_transmitter

Overview:
- SPI-style serial transmitter for a dual-channel 12-bit DAC module (two DAC121S101-class converters sharing SYNC and SCLK, separate data lines).
- It is the output-side counterpart of the microphone capture path: the capture path reads 12-bit samples, this block writes 12-bit samples out to a speaker or amp DAC.
- It accepts a sample pair through a valid/ready handshake, holds it in a one-entry buffer, and shifts a 16-bit frame per channel MSB-first.
- It sits beside Audio_Capture in the top level and is fed by the sound-processing logic.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period (>=1). SCLK = f_clk/(2*CLK_DIV).
- GAP_CYCLES, 4, clk cycles SYNC is held high between frames (>=1).

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample pair offered.
- in_ready  out  1  holding buffer empty; a transfer occurs on a clk edge where in_valid&in_ready.
- sample_a  in  12  channel A code, unsigned straight binary.
- sample_b  in  12  channel B code, unsigned straight binary.
- pd_mode  in  2  DAC power-down bits; latched with the sample pair.
- dac_sync  out  1  frame sync, active low.
- dac_sclk  out  1  serial clock, idles high.
- dac_d0  out  1  channel A serial data.
- dac_d1  out  1  channel B serial data.
- busy  out  1  high while a frame or inter-frame gap is in progress.
- frame_done  out  1  one-cycle pulse on the cycle dac_sync returns high.
- frame_count  out  16  frames completed, wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async assert, any time, including mid-frame):
  - dac_sync=1, dac_sclk=1, dac_d0=dac_d1=0, in_ready=1, busy=0, frame_done=0, frame_count=0.
  - Holding buffer is emptied, FSM goes to IDLE, and a partial frame is abandoned.
- Frame word per channel is {2'b00, pd_mode, sample}, 16 bits, sent MSB first.
- FSM has three states: IDLE, SHIFT, GAP.
  - IDLE: if buffer full, load both shift registers from the buffer and empty it. Next cycle: SHIFT, dac_sync=0, bit15 on d0/d1, busy=1.
  - SHIFT: each bit lasts 2*CLK_DIV cycles.
    - sclk is high for the first CLK_DIV cycles, then low for CLK_DIV cycles.
    - Data changes only at the start of a bit, coincident with sclk rising; the DAC samples on sclk falling.
    - The frame occupies exactly 32*CLK_DIV cycles with dac_sync low.
    - After bit0's low phase: dac_sync=1, sclk=1, d0/d1=0, frame_done=1 for one cycle, frame_count+1, go to GAP.
  - GAP: hold for GAP_CYCLES cycles. At the end, if buffer full, reload and enter SHIFT with no IDLE cycle. Otherwise go to IDLE with busy=0.
- Latency: an accept at edge k with FSM in IDLE gives dac_sync low after edge k+2 (buffer write, then load).
- Throughput:
  - The buffer may be refilled during SHIFT/GAP, so back-to-back frames are spaced 32*CLK_DIV+GAP_CYCLES cycles.
  - in_ready deasserts the cycle after accept and reasserts the cycle after the buffer is loaded into the shift registers.
- Buffer full: in_valid is ignored (no overwrite) and the offered data must be held by the source.
- Underrun: there is no output; the line simply idles (sync high, sclk high).
- Accept and load in the same cycle cannot happen; the buffer is write-when-empty, read-when-full.
- Input changes while in_ready=0 have no effect on the frame in flight.

Decomposition:
- Shared package audio_pkg:
  - constants DAC_WORD_W=16, DAC_DATA_W=12, PD_NORMAL=2'b00.
  - FSM state enum {IDLE, SHIFT, GAP}.
- One natural sub-module: sclk_divider. It produces one-cycle phase strobes (rise/fall) from CLK_DIV and is reset by the FSM at frame start.
- The holding buffer and the two shift registers stay in the top of the block.

Test Plan (CLK_DIV=2, GAP_CYCLES=2):
- Reset release, no input: sync=1, sclk=1, d0=d1=0, in_ready=1, busy=0, frame_count=0 for 100 cycles.
- Single pair A=0xA5C, B=0x3F1, pd=00:
  - sync low 64 cycles, with 16 sclk falling edges.
  - Bits sampled at falls: d0=0x0A5C, d1=0x03F1.
  - frame_done pulses once; frame_count=1.
  - Sync falls 2 cycles after accept.
- in_valid held high with 3 pairs:
  - Frames are 66 cycles apart (sync high exactly 2 cycles between them).
  - Each word is correct; frame_count=3.
  - in_ready is low from accept until load.
- pd=2'b11, A=0xFFF: d0 word = 0x3FFF.
- Reset asserted at bit 7 of a frame: outputs go to idle values asynchronously, frame_count=0, and no frame_done pulse. A new pair after release transmits a full, correct frame.
- Preload frame_count=0xFFFF via 65535 frames (or force): the next frame wraps it to 0x0000.
